// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage_if
// Purpose  : Handshake bundle for alu_result_stage. The upstream operation
//            port and the downstream result port share one interface.
//            master = testbench/producer-consumer side, slave = the stage.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_result_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       carry_in;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       carry_out;
    logic       zero;

    modport master (
        output in_valid, a, b, carry_in, sel, out_ready,
        input  in_ready, out_valid, result, carry_out, zero
    );

    modport slave (
        input  in_valid, a, b, carry_in, sel, out_ready,
        output in_ready, out_valid, result, carry_out, zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : 4-bit ALU (AND/OR/XOR/ADD/ACC/CLR) whose results are queued in
//            a 2-entry FIFO with valid/ready on both sides, 1-cycle latency.
//            Optional macro ALU_SATURATE_EN: ADD and ACC saturate at 4'hF
//            instead of wrapping modulo 16.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage (
    input  wire               clk,
    input  wire               reset,
    alu_result_stage_if.slave bus
);

    localparam logic [2:0] c_SEL_AND = 3'b000;
    localparam logic [2:0] c_SEL_OR  = 3'b001;
    localparam logic [2:0] c_SEL_XOR = 3'b010;
    localparam logic [2:0] c_SEL_ADD = 3'b011;
    localparam logic [2:0] c_SEL_ACC = 3'b100;
    localparam logic [2:0] c_SEL_CLR = 3'b101;
    localparam logic [1:0] c_DEPTH   = 2'd2;

    logic [3:0] r_acc;
    logic [3:0] r_res_mem [2];
    logic       r_cy_mem  [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic       w_out_valid;
    logic       w_accept;
    logic       w_xfer;
    logic [4:0] w_add_sum;
    logic [4:0] w_acc_sum;
    logic [3:0] w_add_res;
    logic       w_add_cy;
    logic [3:0] w_acc_res;
    logic       w_acc_cy;
    logic [3:0] w_res;
    logic       w_cy;
    logic [3:0] w_head_res;
    logic       w_head_cy;

    // Reset gates both handshakes so nothing moves in a reset cycle
    assign bus.in_ready = !reset && (r_count != c_DEPTH);
    assign w_out_valid  = !reset && (r_count != 2'd0);
    assign bus.out_valid = w_out_valid;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_xfer   = w_out_valid && bus.out_ready;

    assign w_add_sum = {1'b0, bus.a} + {1'b0, bus.b} + {4'b0000, bus.carry_in};
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, bus.a} + {4'b0000, bus.carry_in};

`ifdef ALU_SATURATE_EN
    // Any overflow clamps to 4'hF; carry flags that clamping happened
    assign w_add_res = w_add_sum[4] ? 4'hF : w_add_sum[3:0];
    assign w_acc_res = w_acc_sum[4] ? 4'hF : w_acc_sum[3:0];
`else
    assign w_add_res = w_add_sum[3:0];
    assign w_acc_res = w_acc_sum[3:0];
`endif
    assign w_add_cy = w_add_sum[4];
    assign w_acc_cy = w_acc_sum[4];

    // Operation select; CLR and reserved codes both produce a zero result
    always_comb begin
        w_res = 4'h0;
        w_cy  = 1'b0;
        case (bus.sel)
            c_SEL_AND: w_res = bus.a & bus.b;
            c_SEL_OR:  w_res = bus.a | bus.b;
            c_SEL_XOR: w_res = bus.a ^ bus.b;
            c_SEL_ADD: begin
                w_res = w_add_res;
                w_cy  = w_add_cy;
            end
            c_SEL_ACC: begin
                w_res = w_acc_res;
                w_cy  = w_acc_cy;
            end
            default: begin
                w_res = 4'h0;
                w_cy  = 1'b0;
            end
        endcase
    end

    // Accumulator moves only on an accepted ACC or CLR
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= 4'h0;
        end else if (w_accept) begin
            if (bus.sel == c_SEL_ACC) begin
                r_acc <= w_acc_res;
            end else if (bus.sel == c_SEL_CLR) begin
                r_acc <= 4'h0;
            end
        end
    end

    // Two-entry result FIFO with 1-bit wrapping pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_res_mem[i] <= 4'h0;
                r_cy_mem[i]  <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_res_mem[r_wr_ptr] <= w_res;
                r_cy_mem[r_wr_ptr]  <= w_cy;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_xfer) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_xfer})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_res = r_res_mem[r_rd_ptr];
    assign w_head_cy  = r_cy_mem[r_rd_ptr];

    // Outputs read as zero whenever nothing is presented
    assign bus.result    = w_out_valid ? w_head_res : 4'h0;
    assign bus.carry_out = w_out_valid & w_head_cy;
    assign bus.zero      = w_out_valid && (w_head_res == 4'h0);

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_stage
// Purpose  : Self-checking bench for alu_result_stage: directed scenarios
//            followed by random traffic, compared cycle by cycle against a
//            queue-based reference model. Honors ALU_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   m_acc;
    logic last_accept;
    logic [4:0] exp_q [$];

    alu_result_stage_if bus ();

    alu_result_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reduce an arithmetic sum to the stored {carry, result} pair
    function automatic logic [4:0] fold(input int sum);
`ifdef ALU_SATURATE_EN
        if (sum > 15) return 5'h1F;
        return 5'(sum);
`else
        return {1'(sum / 16), 4'(sum % 16)};
`endif
    endfunction

    // Reference behaviour of one accepted operation
    function automatic logic [4:0] model_op(input int a, input int b, input int cin, input int sel);
        logic [4:0] e;
        case (sel)
            0: e = {1'b0, 4'(a & b)};
            1: e = {1'b0, 4'(a | b)};
            2: e = {1'b0, 4'(a ^ b)};
            3: e = fold(a + b + cin);
            4: begin
                e = fold(m_acc + a + cin);
                m_acc = int'(e[3:0]);
            end
            5: begin
                e = 5'h00;
                m_acc = 0;
            end
            default: e = 5'h00;
        endcase
        return e;
    endfunction

    // One clock: check outputs mid-cycle, then advance the model at the edge
    task automatic cycle();
        logic acc_m;
        logic xfer_m;
        acc_m  = 1'b0;
        xfer_m = 1'b0;
        @(negedge clk);
        if (reset) begin
            check_value("rst_in_ready", int'(bus.in_ready), 0);
            check_value("rst_out_valid", int'(bus.out_valid), 0);
            check_value("rst_result", int'(bus.result), 0);
            check_value("rst_carry", int'(bus.carry_out), 0);
            check_value("rst_zero", int'(bus.zero), 0);
        end else begin
            check_value("in_ready", int'(bus.in_ready), int'(exp_q.size() < 2));
            check_value("out_valid", int'(bus.out_valid), int'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check_value("result", int'(bus.result), int'(exp_q[0][3:0]));
                check_value("carry_out", int'(bus.carry_out), int'(exp_q[0][4]));
                check_value("zero", int'(bus.zero), int'(exp_q[0][3:0] == 4'h0));
            end
            acc_m  = bus.in_valid && (exp_q.size() < 2);
            xfer_m = (exp_q.size() > 0) && bus.out_ready;
        end
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            m_acc = 0;
        end else begin
            if (xfer_m) void'(exp_q.pop_front());
            if (acc_m) exp_q.push_back(model_op(int'(bus.a), int'(bus.b), int'(bus.carry_in), int'(bus.sel)));
        end
        last_accept = acc_m;
        #1;
    endtask

    // Present an operation until it is accepted (bounded)
    task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic [2:0] sel);
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
        bus.sel      = sel;
        bus.in_valid = 1'b1;
        last_accept  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_accept) break;
        end
        check_value("offer_accepted", int'(last_accept), 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        m_acc        = 0;
        last_accept  = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = 4'h0;
        bus.b        = 4'h0;
        bus.carry_in = 1'b0;
        bus.sel      = 3'b000;
        bus.out_ready = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);

        // Logic operations
        offer(4'h1, 4'hE, 1'b0, 3'b000);
        offer(4'h1, 4'hE, 1'b0, 3'b001);
        offer(4'h1, 4'hE, 1'b0, 3'b010);
        idle(2);

        // Add with carry into overflow
        offer(4'hE, 4'h1, 1'b1, 3'b011);
        idle(2);

        // Accumulate chain
        offer(4'h0, 4'h0, 1'b0, 3'b101);
        for (int i = 0; i < 3; i++) offer(4'h5, 4'h0, 1'b0, 3'b100);
        offer(4'h1, 4'h0, 1'b0, 3'b100);
        offer(4'h3, 4'h9, 1'b1, 3'b110);
        offer(4'h3, 4'h9, 1'b1, 3'b111);
        idle(2);

        // Backpressure: third op held until the consumer drains
        bus.out_ready = 1'b0;
        offer(4'h1, 4'h1, 1'b0, 3'b011);
        offer(4'h2, 4'h2, 1'b0, 3'b011);
        bus.a = 4'h3; bus.b = 4'h3; bus.sel = 3'b011; bus.in_valid = 1'b1;
        idle(3);
        bus.out_ready = 1'b1;
        offer(4'h3, 4'h3, 1'b0, 3'b011);
        idle(3);

        // Reset mid-stream with two buffered entries and acc = 7
        offer(4'h0, 4'h0, 1'b0, 3'b101);
        offer(4'h7, 4'h0, 1'b0, 3'b100);
        bus.out_ready = 1'b0;
        offer(4'h4, 4'h4, 1'b0, 3'b011);
        bus.in_valid = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        cycle();
        bus.out_ready = 1'b1;
        offer(4'h0, 4'h0, 1'b0, 3'b100);
        idle(2);

        // Random traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = 4'($urandom_range(0, 15));
            bus.b         = 4'($urandom_range(0, 15));
            bus.carry_in  = 1'($urandom_range(0, 1));
            bus.sel       = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            reset         = ($urandom_range(0, 79) == 0);
            cycle();
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
